mc_controller: RTL and testbench

Moore-style control FSM for the multicycle RV32I core. It sequences one shared ALU and one unified instruction/data memory across several cycles per instruction, and drives every mux select and write enable in the multicycle datapath. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal. Any other opcode retires as a no-op.

---
 rtl/mc_controller.sv | 171 +++++++++++++++++
 tb/tb_mc_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for the multicycle RV32I core.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   op, funct3, funct7b5       instruction fields from the instruction register
//   Zero                       ALU zero flag, used only in BEQ
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegWrite, ALUControl   datapath selects and write enables
//   state_o                    current state code
//   instr_done                 one-cycle pulse in the final state of an instruction
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic [3:0] state_o,
    output logic       instr_done
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q, state_d;
    logic       pc_update, branch, reg_write, mem_write, ir_write, done;
    logic [1:0] alu_op;
    logic [2:0] alu_dec;
    logic       supported;

    assign supported = (op == OP_LW) | (op == OP_SW) | (op == OP_R) |
                       (op == OP_I) | (op == OP_BEQ) | (op == OP_JAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                                (op == OP_R)   ? EXECUTER :
                                (op == OP_I)   ? EXECUTEI :
                                (op == OP_BEQ) ? BEQ :
                                (op == OP_JAL) ? JAL : FETCH;
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        done      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                done    = ~supported;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                done      = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                done    = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces FETCH asynchronously; gating the enables here also kills
    // any write belonging to an instruction aborted mid-flight.
    assign PCWrite    = (pc_update | (branch & Zero)) & ~reset;
    assign IRWrite    = ir_write & ~reset;
    assign RegWrite   = reg_write & ~reset;
    assign MemWrite   = mem_write & ~reset;
    assign instr_done = done & ~reset;
    assign state_o    = state_q;

    assign ImmSrc = (op == OP_SW)  ? 2'b01 :
                    (op == OP_BEQ) ? 2'b10 :
                    (op == OP_JAL) ? 2'b11 : 2'b00;

    // Subtract only for R-type sub; op[5] separates R-type from I-type addi.
    assign alu_dec = (funct3 == 3'b000) ? ((funct7b5 & op[5]) ? 3'b001 : 3'b000) :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;

    assign ALUControl = (alu_op == 2'b01) ? 3'b001 :
                        (alu_op == 2'b10) ? alu_dec : 3'b000;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    int         total = 0;
    int         passed = 0;
    int         done_cnt, mw_cnt;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
        .state_o(state_o), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick;
        done_cnt += int'(instr_done);
        mw_cnt   += int'(MemWrite);
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        done_cnt = 0; mw_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        #3;
        for (int i = 0; i < 2; i++) begin
            check("rst_state", 8'(state_o), 8'd0);
            check("rst_we", {3'b0, PCWrite, IRWrite, RegWrite, MemWrite, instr_done}, 8'd0);
            check("rst_srcb", 8'(ALUSrcB), 8'd2);
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        #1;
        check("fetch_irw", 8'(IRWrite), 8'd1);
        check("fetch_pcw", 8'(PCWrite), 8'd1);
        check("fetch_res", 8'(ResultSrc), 8'd2);

        // lw
        start(7'b0000011, 3'b010, 1'b0);
        check("lw_s0", 8'(state_o), 8'd0); tick;
        check("lw_s1", 8'(state_o), 8'd1);
        check("lw_pcw_dec", 8'(PCWrite), 8'd0); tick;
        check("lw_s2", 8'(state_o), 8'd2);
        check("lw_alu", 8'(ALUControl), 8'd0);
        check("lw_imm", 8'(ImmSrc), 8'd0);
        check("lw_rw2", 8'(RegWrite), 8'd0); tick;
        check("lw_s3", 8'(state_o), 8'd3);
        check("lw_adr", 8'(AdrSrc), 8'd1);
        check("lw_rw3", 8'(RegWrite), 8'd0); tick;
        check("lw_s4", 8'(state_o), 8'd4);
        check("lw_rw4", 8'(RegWrite), 8'd1);
        check("lw_res", 8'(ResultSrc), 8'd1);
        check("lw_done4", 8'(instr_done), 8'd1); tick;
        check("lw_back", 8'(state_o), 8'd0);
        check("lw_done_cnt", 8'(done_cnt), 8'd1);

        // sw
        start(7'b0100011, 3'b010, 1'b0);
        tick;
        check("sw_s1", 8'(state_o), 8'd1);
        check("sw_imm", 8'(ImmSrc), 8'd1); tick;
        check("sw_s2", 8'(state_o), 8'd2); tick;
        check("sw_s5", 8'(state_o), 8'd5);
        check("sw_mw", 8'(MemWrite), 8'd1);
        check("sw_adr", 8'(AdrSrc), 8'd1); tick;
        check("sw_back", 8'(state_o), 8'd0);
        check("sw_mw_cnt", 8'(mw_cnt), 8'd1);
        check("sw_done_cnt", 8'(done_cnt), 8'd1);

        // R-type sub, then and/or/slt
        start(7'b0110011, 3'b000, 1'b1);
        tick; tick;
        check("sub_s6", 8'(state_o), 8'd6);
        check("sub_alu", 8'(ALUControl), 8'd1);
        check("sub_srca", 8'(ALUSrcA), 8'd2);
        check("sub_srcb", 8'(ALUSrcB), 8'd0); tick;
        check("sub_s8", 8'(state_o), 8'd8);
        check("sub_rw", 8'(RegWrite), 8'd1); tick;
        check("sub_back", 8'(state_o), 8'd0);
        start(7'b0110011, 3'b010, 1'b0);
        tick; tick;
        check("slt_alu", 8'(ALUControl), 8'd5); tick; tick;
        start(7'b0110011, 3'b110, 1'b0);
        tick; tick;
        check("or_alu", 8'(ALUControl), 8'd3); tick; tick;
        start(7'b0110011, 3'b111, 1'b0);
        tick; tick;
        check("and_alu", 8'(ALUControl), 8'd2); tick; tick;

        // I-type with the sub encoding still adds
        start(7'b0010011, 3'b000, 1'b1);
        tick; tick;
        check("addi_s7", 8'(state_o), 8'd7);
        check("addi_alu", 8'(ALUControl), 8'd0);
        check("addi_srcb", 8'(ALUSrcB), 8'd1); tick;
        check("addi_s8", 8'(state_o), 8'd8); tick;
        check("addi_back", 8'(state_o), 8'd0);

        // beq taken
        start(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b1;
        tick;
        check("beq_dec_pcw", 8'(PCWrite), 8'd0);
        check("beq_imm", 8'(ImmSrc), 8'd2); tick;
        check("beqt_s9", 8'(state_o), 8'd9);
        check("beqt_pcw", 8'(PCWrite), 8'd1);
        check("beqt_alu", 8'(ALUControl), 8'd1);
        check("beqt_done", 8'(instr_done), 8'd1); tick;
        check("beqt_back", 8'(state_o), 8'd0);
        // beq not taken
        start(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b0;
        tick; tick;
        check("beqn_s9", 8'(state_o), 8'd9);
        check("beqn_pcw", 8'(PCWrite), 8'd0); tick;
        check("beqn_back", 8'(state_o), 8'd0);

        // jal
        start(7'b1101111, 3'b000, 1'b0);
        tick;
        check("jal_imm", 8'(ImmSrc), 8'd3); tick;
        check("jal_s10", 8'(state_o), 8'd10);
        check("jal_pcw", 8'(PCWrite), 8'd1);
        check("jal_res", 8'(ResultSrc), 8'd0);
        check("jal_srca", 8'(ALUSrcA), 8'd1); tick;
        check("jal_s8", 8'(state_o), 8'd8);
        check("jal_rw", 8'(RegWrite), 8'd1); tick;
        check("jal_back", 8'(state_o), 8'd0);

        // unsupported opcode
        start(7'b0000000, 3'b000, 1'b0);
        tick;
        check("nop_s1", 8'(state_o), 8'd1);
        check("nop_done", 8'(instr_done), 8'd1);
        check("nop_we", {4'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'd0); tick;
        check("nop_back", 8'(state_o), 8'd0);

        // asynchronous reset during MEMWRITE
        start(7'b0100011, 3'b010, 1'b0);
        tick; tick; tick;
        check("abort_s5", 8'(state_o), 8'd5);
        check("abort_mw_pre", 8'(MemWrite), 8'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_mw", 8'(MemWrite), 8'd0);
        check("abort_state", 8'(state_o), 8'd0);
        check("abort_done", 8'(instr_done), 8'd0);
        @(posedge clk);
        #2;
        check("abort_hold", 8'(state_o), 8'd0);
        reset = 1'b0;
        #1;
        check("abort_fetch", 8'(IRWrite), 8'd1);
        tick;
        check("abort_next", 8'(state_o), 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
